// File: rtl/mul_share_arb.sv
// Two-requester round-robin front end for a shared combinational multiplier.
// A request is granted in IDLE, its operands are latched, and the product is
// registered one cycle later together with the owner's ID and a valid pulse.

// Combinational unsigned N x N multiplier producing the full 2N-bit product.
module mul #(
  parameter int N = 4
) (
  output logic [2*N-1:0] Y,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B
);

  assign Y = {{N{1'b0}}, A} * {{N{1'b0}}, B};

endmodule

// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting; samples req0/req1 and grants one at each edge
// MUL   | operands latched; product written to y at the next edge
module mul_share_arb #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic [N-1:0]    a0,
  input  logic [N-1:0]    b0,
  input  logic            req1,
  input  logic [N-1:0]    a1,
  input  logic [N-1:0]    b1,
  output logic            gnt0,
  output logic            gnt1,
  output logic [2*N-1:0]  y,
  output logic            y_valid,
  output logic            y_id,
  output logic            busy,
  output logic [CW-1:0]   op_count
);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t         state;
  logic           last;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [2*N-1:0] prod;
  logic           grant_any;
  logic           grant_id;

  mul #(.N(N)) u_mul (
    .Y (prod),
    .A (op_a),
    .B (op_b)
  );

  // Round-robin pick: a lone requester wins; on contention the one that was
  // not granted last time wins. last also tags the operation being multiplied.
  always_comb begin
    grant_any = req0 | req1;
    grant_id  = req1 & (~req0 | ~last);
  end

  // Sequencing FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      op_a     <= '0;
      op_b     <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      y        <= '0;
      y_valid  <= 1'b0;
      y_id     <= 1'b0;
      busy     <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          y_valid <= 1'b0;
          if (grant_any) begin
            op_a  <= grant_id ? a1 : a0;
            op_b  <= grant_id ? b1 : b0;
            gnt0  <= ~grant_id;
            gnt1  <= grant_id;
            last  <= grant_id;
            busy  <= 1'b1;
            state <= MUL;
          end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            busy <= 1'b0;
          end
        end
        MUL: begin
          y        <= prod;
          y_id     <= last;
          y_valid  <= 1'b1;
          op_count <= op_count + CW'(1);
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          y_valid <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed and randomized bench for mul_share_arb with a transaction-level
// reference model (arbitration rule, product, result counter).
module tb_mul_share_arb;

  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk;
  logic          reset;
  logic          req0, req1;
  logic [N-1:0]  a0, b0, a1, b1;
  logic          gnt0, gnt1;
  logic [2*N-1:0] y;
  logic          y_valid;
  logic          y_id;
  logic          busy;
  logic [CW-1:0] op_count;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit m_last;
  int m_count;
  int m_y;
  bit m_id;

  mul_share_arb #(.N(N), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .a0       (a0),
    .b0       (b0),
    .req1     (req1),
    .a1       (a1),
    .b1       (b1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .y        (y),
    .y_valid  (y_valid),
    .y_id     (y_id),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt0"}, 32'(gnt0), 0);
    chk({tag, "_gnt1"}, 32'(gnt1), 0);
    chk({tag, "_yv"}, 32'(y_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_yid"}, 32'(y_id), 0);
    chk({tag, "_cnt"}, 32'(op_count), 0);
  endtask

  task automatic model_reset();
    m_last  = 1'b1;
    m_count = 0;
    m_y     = 0;
    m_id    = 1'b0;
  endtask

  // Entered at a falling edge; leaves at a falling edge.
  task automatic apply_reset();
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    a0 = N'($urandom); b0 = N'($urandom); a1 = N'($urandom); b1 = N'($urandom);
    #1;
    chk_zero("rst_now");
    repeat (2) @(negedge clk);
    chk_zero("rst_held");
    reset = 1'b0;
    model_reset();
  endtask

  // One request opportunity, called at a falling edge while the DUT is idle.
  // With no request, covers a single idle cycle; otherwise covers the grant
  // cycle and the result cycle. scramble changes inputs during the MUL cycle.
  task automatic issue(input bit r0, input bit r1,
                       input logic [N-1:0] xa0, input logic [N-1:0] xb0,
                       input logic [N-1:0] xa1, input logic [N-1:0] xb1,
                       input bit scramble);
    bit win;
    int p;
    req0 = r0; req1 = r1; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
    if (!r0 && !r1) begin
      @(negedge clk);
      chk("idle_gnt0", 32'(gnt0), 0);
      chk("idle_gnt1", 32'(gnt1), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_yv", 32'(y_valid), 0);
      chk("idle_y_hold", 32'(y), 32'(m_y));
      return;
    end
    if (r0 && r1) win = ~m_last;
    else          win = r1;
    p = win ? int'(xa1) * int'(xb1) : int'(xa0) * int'(xb0);
    @(negedge clk);
    chk("gnt0", 32'(gnt0), 32'(!win));
    chk("gnt1", 32'(gnt1), 32'(win));
    chk("busy_mul", 32'(busy), 1);
    chk("yv_in_gnt", 32'(y_valid), 0);
    chk("y_hold", 32'(y), 32'(m_y));
    chk("yid_hold", 32'(y_id), 32'(m_id));
    m_last = win;
    if (scramble) begin
      req0 = 1'($urandom); req1 = 1'($urandom);
      a0 = N'($urandom); b0 = N'($urandom); a1 = N'($urandom); b1 = N'($urandom);
    end
    @(negedge clk);
    m_count = (m_count + 1) % (1 << CW);
    m_y     = p;
    m_id    = win;
    chk("y_valid", 32'(y_valid), 1);
    chk("y", 32'(y), 32'(m_y));
    chk("y_id", 32'(y_id), 32'(m_id));
    chk("op_count", 32'(op_count), 32'(m_count));
    chk("gnt0_clr", 32'(gnt0), 0);
    chk("gnt1_clr", 32'(gnt1), 0);
    chk("busy_clr", 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_reset();

    apply_reset();

    // directed: single requests and operand extremes
    issue(1'b1, 1'b0, 4'd3, 4'd5, 4'd0, 4'd0, 1'b0);
    chk("single_y15", 32'(y), 32'd15);
    issue(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("yv_drop", 32'(y_valid), 0);
    issue(1'b0, 1'b1, 4'd1, 4'd1, 4'd15, 4'd15, 1'b0);
    chk("max_yE1", 32'(y), 32'hE1);
    issue(1'b1, 1'b0, 4'd0, 4'd9, 4'd3, 4'd3, 1'b0);
    chk("zero_y", 32'(y), 32'd0);

    // contention from reset: held requests alternate 0,1,0,1
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, 4'd2, 4'd3, 4'd4, 4'd5, 1'b0);
      chk("cont_y", 32'(y), (i % 2 == 0) ? 32'd6 : 32'd20);
    end

    // randomized traffic, including input changes while multiplying
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom), 1'($urandom), N'($urandom), N'($urandom),
            N'($urandom), N'($urandom), 1'($urandom));
    end

    // reset during MUL discards the operation
    req0 = 1'b1; req1 = 1'b0; a0 = 4'd7; b0 = 4'd7;
    @(posedge clk);
    #2;
    chk("mid_gnt0", 32'(gnt0), 1);
    chk("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk_zero("mid_rst_now");
    @(negedge clk);
    chk_zero("mid_rst_edge");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    issue(1'b1, 1'b1, 4'd6, 4'd2, 4'd5, 4'd5, 1'b0);
    chk("post_rst_prio", 32'(y_id), 0);

    // counter wrap over 256 results
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      bit r;
      r = 1'($urandom);
      issue(!r, r, N'($urandom), N'($urandom), N'($urandom), N'($urandom), 1'b0);
      if (i == 254) chk("wrap_255", 32'(op_count), 32'd255);
    end
    chk("wrap_0", 32'(op_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
